// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state encoding and round-robin pick helper for rr_arbiter4
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int ID_W = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} st_e;
  typedef struct packed {
    logic found;
    logic [ID_W-1:0] idx;
  } pick_t;
  // Descending scan so the last hit is the highest-priority requester.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [ID_W-1:0] ptr);
    pick_t p;
    logic [ID_W-1:0] k;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + ID_W'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx = k;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/Decoder.sv
// Decoder: 2-to-4 one-hot decoder with enable
module Decoder (
  input  logic       enable,
  input  logic       s0,
  input  logic       s1,
  output logic [3:0] y
);
  always_comb y = enable ? 4'b0001 << {s1, s0} : 4'b0000;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with optional hold-time limit
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             timeout
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  st_e state_q, state_d;
  logic [ID_W-1:0] id_q, id_d, ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic timeout_q, timeout_d;
  logic keep, expire;
  pick_t pk;
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    ptr_d = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d = 1'b0;
    keep = state_q == ST_BUSY && req[id_q];
    expire = MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST;
    // A revoked owner is masked out; a releasing owner already has req low.
    pk = rr_pick(keep ? req & ~(N_REQ'(1) << id_q) : req, ptr_q);
    if (!arb_en) state_d = ST_IDLE;
    else if (keep && !expire) hold_cnt_d = hold_cnt_q == 8'hFF ? hold_cnt_q : hold_cnt_q + 8'd1;
    else begin
      timeout_d = keep;
      state_d = pk.found ? ST_BUSY : ST_IDLE;
      if (pk.found) begin
        id_d = pk.idx;
        ptr_d = pk.idx + 2'd1;
        hold_cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q <= '0;
      ptr_q <= '0;
      hold_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign busy = state_q == ST_BUSY;
  assign grant_id = id_q;
  assign timeout = timeout_q;
  Decoder u_dec (.enable(busy), .s0(id_q[0]), .s1(id_q[1]), .y(grant));
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed bench with a behavioural arbiter model for MAX_HOLD=4 and MAX_HOLD=0
module tb_rr_arbiter4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arb_en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] g4, g0;
  logic [1:0] id4, id0;
  logic b4, b0, t4, t0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(4)) d4 (.clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .grant(g4), .grant_id(id4), .busy(b4), .timeout(t4));
  rr_arbiter4 #(.MAX_HOLD(0)) d0 (.clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .grant(g0), .grant_id(id0), .busy(b0), .timeout(t0));

  typedef struct {
    int own;
    int ptr;
    int hold;
    bit to;
  } m_t;

  m_t m4, m0;

  function automatic m_t m_reset();
    m_t m;
    m.own = -1;
    m.ptr = 0;
    m.hold = 0;
    m.to = 1'b0;
    return m;
  endfunction

  function automatic m_t step(m_t m, bit en, logic [3:0] r, int mh);
    m_t n;
    int excl;
    n = m;
    n.to = 1'b0;
    excl = -1;
    if (!en) begin
      n.own = -1;
      return n;
    end
    if (m.own >= 0 && r[m.own]) begin
      if (mh == 0 || m.hold < mh - 1) begin
        n.hold = (m.hold < 255) ? m.hold + 1 : 255;
        return n;
      end
      n.to = 1'b1;
      excl = m.own;
    end
    n.own = -1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m.ptr + k) % 4;
      if (r[c] && c != excl) begin
        n.own = c;
        n.ptr = (c + 1) % 4;
        n.hold = 0;
        return n;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= m_reset();
      m0 <= m_reset();
    end else begin
      m4 <= step(m4, arb_en, req, 4);
      m0 <= step(m0, arb_en, req, 0);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input m_t m, input logic [3:0] g, input logic [1:0] id,
                     input logic b, input logic t);
    chk({nm, ".grant"}, int'(g), m.own < 0 ? 0 : (1 << m.own));
    chk({nm, ".busy"}, int'(b), m.own >= 0 ? 1 : 0);
    chk({nm, ".timeout"}, int'(t), int'(m.to));
    if (m.own >= 0) chk({nm, ".grant_id"}, int'(id), m.own);
  endtask

  always @(negedge clk) begin
    cmp("d4", m4, g4, id4, b4, t4);
    cmp("d0", m0, g0, id0, b0, t0);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    arb_en = 1'b0;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("reset_grant", int'(g4), 0);
    chk("reset_busy", int'(b4), 0);
    chk("reset_timeout", int'(t4), 0);
    chk("reset_id", int'(id4), 0);
    do_reset();
    arb_en = 1'b1;
    req = 4'b0101;
    @(negedge clk);
    chk("s1_first_grant", int'(g4), 4'b0001);
    chk("s1_ptr", int'(d4.ptr_q), 1);
    req = 4'b0100;
    @(negedge clk);
    chk("s1_handover", int'(g4), 4'b0100);
    chk("s1_handover_busy", int'(b4), 1);
    req = 4'b0000;
    @(negedge clk);
    chk("s1_release", int'(g4), 0);

    do_reset();
    arb_en = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    for (int c = 0; c < 17; c++) begin
      chk("s2_rotate", int'(g4), 1 << ((c / 4) % 4));
      chk("s2_timeout", int'(t4), (c > 0 && c % 4 == 0) ? 1 : 0);
      chk("s2_nolimit", int'(g0), 4'b0001);
      @(negedge clk);
    end

    do_reset();
    arb_en = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("s3_grant", int'(g4), (c % 5 < 4) ? 4'b0100 : 0);
      chk("s3_timeout", int'(t4), (c % 5 == 4) ? 1 : 0);
      @(negedge clk);
    end

    do_reset();
    arb_en = 1'b1;
    req = 4'b0010;
    @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      chk("s4_grant", int'(g0), 4'b0010);
      chk("s4_timeout", int'(t0), 0);
      @(negedge clk);
    end
    chk("s4_hold_sat", int'(d0.hold_cnt_q), 255);

    do_reset();
    arb_en = 1'b1;
    req = 4'b0101;
    @(negedge clk);
    chk("s5_grant", int'(g4), 4'b0001);
    arb_en = 1'b0;
    @(negedge clk);
    chk("s5_disabled", int'(g4), 0);
    chk("s5_disabled_to", int'(t4), 0);
    chk("s5_ptr_kept", int'(d4.ptr_q), 1);
    arb_en = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    chk("s5_resume", int'(g4), 4'b0010);

    do_reset();
    arb_en = 1'b1;
    req = 4'b0010;
    @(negedge clk);
    chk("s6_grant", int'(g4), 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_grant", int'(g4), 0);
    chk("s6_async_busy", int'(b4), 0);
    chk("s6_async_to", int'(t4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000;
    @(negedge clk);
    chk("s6_regrant", int'(g4), 4'b1000);
    chk("s6_ptr_wrap", int'(d4.ptr_q), 0);
    req = 4'b0000;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
